// File: rtl/rsa_pkg.sv
// rsa_pkg: shared widths and Montgomery FSM states for the RSA datapath
package rsa_pkg;
  localparam int N = 512;
  localparam int ADDER_W = N + 2;
  localparam int ADD_RES_W = ADDER_W + 1;
  localparam int I_W = $clog2(N);
  typedef enum logic [2:0] {
    S_IDLE, S_CHK_A, S_ADD_B, S_CHK_C, S_ADD_M, S_SHIFT, S_SUB_M, S_DONE
  } state_e;
endpackage

// File: rtl/adder.sv
// adder: multi-cycle add/subtract; result[W] is carry-out (no-borrow on subtract)
// Ports: start pulses an op on in_a/in_b/subtract (held stable until done);
//        done rises LAT cycles later and stays high until the next start.
module adder
  import rsa_pkg::*;
#(
  parameter int W = ADDER_W,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         subtract,
  output logic [W:0]   result,
  output logic         done
);
  localparam int CW = $clog2(LAT + 1);
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic [W:0]    sum;
  // two's complement subtract: a + ~b + 1, carry-out set means a >= b
  assign sum = {1'b0, in_a} + {1'b0, in_b ^ {W{subtract}}} + (W+1)'(subtract);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (start) begin
      cnt_q <= CW'(LAT - 1);
      run_q <= 1'b1;
      done  <= 1'b0;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_q  <= 1'b0;
        done   <= 1'b1;
        result <= sum;
      end else cnt_q <= cnt_q - 1'b1;
    end
endmodule

// File: rtl/montgomery_mult.sv
// montgomery_mult: radix-2 bit-serial Montgomery product in_a*in_b*2^-N mod in_m
// Ports: start (1-cycle, accepted in IDLE or the done cycle) samples in_a/in_b/in_m;
//        result valid from the done pulse; busy high while an operation runs.
module montgomery_mult
  import rsa_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy
);
  state_e               state_q, state_d;
  logic [N-1:0]         a_q, b_q, m_q, result_d;
  logic [ADDER_W-1:0]   c_q, c_d, add_a, add_b;
  logic [I_W-1:0]       i_q, i_d;
  logic [ADD_RES_W-1:0] add_res;
  logic                 add_start, add_sub, add_done, accept;
  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);
  assign done   = state_q == S_DONE;
  assign busy   = state_q != S_IDLE && state_q != S_DONE;
  // the final subtract is launched from SHIFT, so the adder already sees the shifted C
  assign add_a   = state_q == S_SHIFT ? c_q >> 1 : c_q;
  assign add_b   = (state_q == S_CHK_A || state_q == S_ADD_B) ? {2'b0, b_q} : {2'b0, m_q};
  assign add_sub = state_q == S_SHIFT || state_q == S_SUB_M;
  adder u_adder (
    .clk(clk), .resetn(resetn), .start(add_start), .in_a(add_a), .in_b(add_b),
    .subtract(add_sub), .result(add_res), .done(add_done)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      i_q     <= '0;
      result  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      i_q     <= i_d;
      result  <= result_d;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
        m_q <= in_m;
      end
    end
  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    i_d       = i_q;
    result_d  = result;
    add_start = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = accept ? S_CHK_A : S_IDLE;
        c_d     = accept ? '0 : c_q;
        i_d     = accept ? '0 : i_q;
      end
      S_CHK_A: begin
        add_start = a_q[i_q];
        state_d   = a_q[i_q] ? S_ADD_B : S_CHK_C;
      end
      S_ADD_B: if (add_done) begin
        c_d     = add_res[ADDER_W-1:0];
        state_d = S_CHK_C;
      end
      S_CHK_C: begin
        add_start = c_q[0];
        state_d   = c_q[0] ? S_ADD_M : S_SHIFT;
      end
      S_ADD_M: if (add_done) begin
        c_d     = add_res[ADDER_W-1:0];
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        c_d       = c_q >> 1;
        add_start = i_q == I_W'(N - 1);
        i_d       = i_q == I_W'(N - 1) ? i_q : i_q + 1'b1;
        state_d   = i_q == I_W'(N - 1) ? S_SUB_M : S_CHK_A;
      end
      S_SUB_M: if (add_done) begin
        result_d = add_res[ADD_RES_W-1] ? add_res[N-1:0] : c_q[N-1:0];
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_montgomery_mult.sv
// tb_montgomery_mult: directed-vector check of the Montgomery multiplier
module tb_montgomery_mult;
  localparam int LIMIT = 20000;
  logic         clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [511:0] in_a = '0, in_b = '0, in_m = '0;
  logic [511:0] result;
  logic         done, busy;
  logic [511:0] big_m, big_a;
  int           n_checks = 0, n_fail = 0, n_starts = 0, s0;

  montgomery_mult dut (
    .clk(clk), .resetn(resetn), .start(start), .in_a(in_a), .in_b(in_b),
    .in_m(in_m), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (dut.add_start) n_starts++;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [511:0] a, b, m);
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    in_m  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 512'(done), 512'd1);
  endtask

  task automatic run_check(input string tag, input logic [511:0] a, b, m, exp);
    pulse_start(a, b, m);
    wait_done(tag);
    check(tag, result, exp);
  endtask

  initial begin
    big_m = {512{1'b1}};
    big_a = big_m - 512'd1;
    repeat (3) @(negedge clk);
    check("rst_result", result, '0);
    check("rst_busy", 512'(busy), '0);
    check("rst_done", 512'(done), '0);
    resetn = 1'b1;
    pulse_start(512'd5, 512'd7, 512'd13);
    check("busy_after_start", 512'(busy), 512'd1);
    repeat (8) @(negedge clk);
    in_a  = 512'd1;
    in_b  = 512'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_busy_start");
    check("5x7_mod13", result, 512'd1);
    in_a  = 512'd9;
    in_b  = 512'd7;
    in_m  = 512'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 512'(busy), 512'd1);
    wait_done("b2b");
    check("9x7_mod13", result, 512'd7);
    run_check("1x1_mod13", 512'd1, 512'd1, 512'd13, 512'd3);
    s0 = n_starts;
    run_check("0x12_mod13", 512'd0, 512'd12, 512'd13, 512'd0);
    check("a0_adder_starts", 512'(n_starts - s0), 512'd1);
    run_check("big_m", big_a, big_a, big_m, 512'd1);
    pulse_start(512'd5, 512'd7, 512'd13);
    repeat (50) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_result", result, '0);
    check("midrst_busy", 512'(busy), '0);
    check("midrst_done", 512'(done), '0);
    @(negedge clk);
    resetn = 1'b1;
    run_check("after_rst", 512'd5, 512'd7, 512'd13, 512'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
